// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings and the
// default reset vector / instruction memory depth.
package if_stage_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int          IM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

endpackage

// File: rtl/if_stage_npc.sv
// Combinational next-PC selector: sequential, branch, j/jal and jr targets.
// Branch and jump targets are relative to the instruction sitting in D.
module if_stage_npc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_d,
  input  logic        valid_d,
  input  logic [1:0]  npc_op,
  input  logic        b_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;

  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  // A bubble in D carries no control-flow intent, so it always falls through.
  always_comb begin
    npc = pc_plus4;
    if (valid_d) begin
      case (npc_op_e'(npc_op))
        NPC_SEQ:    npc = pc_plus4;
        NPC_BRANCH: npc = b_taken ? (pc_d + 32'd4 + br_offset) : pc_plus4;
        NPC_JUMP:   npc = {pc_d[31:28], j_index, 2'b00};
        NPC_JR:     npc = jr_target;
        default:    npc = pc_plus4;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, address-error detection and the
// IF/ID pipeline register. Redirect beats stall beats normal advance.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        b_taken,
  input  logic [15:0] imm16_D,
  input  logic [25:0] j_index_D,
  input  logic [31:0] jr_target,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        adel_D,
  output logic        valid_D
);

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

  logic [31:0] pc;
  logic [31:0] npc;
  logic        adel;

  assign imem_addr = pc;
  assign adel      = (pc[1:0] != 2'b00) | (pc < PC_RESET) | (pc > PC_LAST);

  if_stage_npc u_npc (
    .pc        (pc),
    .pc_d      (pc_D),
    .valid_d   (valid_D),
    .npc_op    (npc_op),
    .b_taken   (b_taken),
    .imm16     (imm16_D),
    .j_index   (j_index_D),
    .jr_target (jr_target),
    .npc       (npc)
  );

  // Faulting fetches still flow down the pipe, but with a zeroed instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= PC_RESET;
      instr_D <= 32'd0;
      pc_D    <= 32'd0;
      pc8_D   <= 32'd0;
      adel_D  <= 1'b0;
      valid_D <= 1'b0;
    end else if (redirect) begin
      pc      <= redirect_pc;
      instr_D <= 32'd0;
      pc_D    <= 32'd0;
      pc8_D   <= 32'd0;
      adel_D  <= 1'b0;
      valid_D <= 1'b0;
    end else if (!stall) begin
      pc      <= npc;
      instr_D <= adel ? 32'd0 : imem_data;
      pc_D    <= pc;
      pc8_D   <= pc + 32'd8;
      adel_D  <= adel;
      valid_D <= 1'b1;
    end
  end

endmodule
